// File: rtl/multicycle_divider_pkg.sv
// JZJCoreFTypes: shared types and constants for the multi-cycle divider.
package JZJCoreFTypes;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } DivState_t;

    typedef enum logic [2:0] {
        OP_DIV  = 3'b100,
        OP_DIVU = 3'b101,
        OP_REM  = 3'b110,
        OP_REMU = 3'b111
    } DivOp_t;

    localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/multicycle_divider_sign_fixup.sv
// divider_sign_fixup: picks quotient or remainder and restores its sign.
module divider_sign_fixup
    import JZJCoreFTypes::*;
(
    input  logic [31:0] quotient_i,
    input  logic [31:0] remainder_i,
    input  DivOp_t      op_i,
    input  logic        neg_quo_i,
    input  logic        neg_rem_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = (op_i == OP_DIV || op_i == OP_DIVU)
                 ? (neg_quo_i ? -quotient_i : quotient_i)
                 : (neg_rem_i ? -remainder_i : remainder_i);
    end

endmodule

// File: rtl/multicycle_divider.sv
// multicycle_divider: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define JZJCOREF_DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow without iterating.
module multicycle_divider
    import JZJCoreFTypes::*;
#(
    parameter int ITERATIONS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [4:0]  rdAddressIn,
    output logic        busy,
    output logic [31:0] rd,
    output logic [4:0]  rdAddress,
    output logic        rdWriteEnable
);

    if (ITERATIONS != 32) begin : g_bad_iterations
        $error("multicycle_divider: ITERATIONS must be 32");
    end

    localparam logic [4:0] CNT_INIT = 5'(ITERATIONS - 1);

    DivState_t   state_q, state_d;
    DivOp_t      op_q, op_d;
    logic [4:0]  addr_q, addr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rd_q, rd_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;

    logic        is_signed;
    logic [31:0] dvd_mag, dvs_mag;
    logic [32:0] shifted;
    logic [31:0] trial;
    logic        ge;
    logic [31:0] result;

    divider_sign_fixup u_fixup (
        .quotient_i (quo_q),
        .remainder_i(rem_q),
        .op_i       (op_q),
        .neg_quo_i  (neg_quo_q),
        .neg_rem_i  (neg_rem_q),
        .result_o   (result)
    );

    always_comb begin
        is_signed = ~funct3[0];
        dvd_mag   = (is_signed && dividend[31]) ? -dividend : dividend;
        dvs_mag   = (is_signed && divisor[31]) ? -divisor : divisor;
        shifted   = {rem_q, quo_q[31]};
        trial     = shifted[31:0] - dvs_q;
        // a successful trial always leaves a value below the divisor, so 32 bits suffice
        ge        = shifted >= {1'b0, dvs_q};
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rd_d      = rd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        we_d      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                op_d      = DivOp_t'(funct3);
                addr_d    = rdAddressIn;
                dvs_d     = dvs_mag;
                quo_d     = dvd_mag;
                rem_d     = '0;
                neg_quo_d = is_signed && (dividend[31] ^ divisor[31]) && (divisor != '0);
                neg_rem_d = is_signed && dividend[31];
                cnt_d     = CNT_INIT;
                state_d   = DIVIDE;
`ifdef JZJCOREF_DIV_EARLY_OUT_EN
                if (divisor == '0 || (is_signed && dividend == 32'h8000_0000 && divisor == '1)) begin
                    quo_d   = (divisor == '0) ? '1 : 32'h8000_0000;
                    rem_d   = (divisor == '0) ? dvd_mag : '0;
                    state_d = FINISH;
                end
`endif
            end
            DIVIDE: begin
                rem_d   = ge ? trial : shifted[31:0];
                quo_d   = {quo_q[30:0], ge};
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == '0) ? FINISH : DIVIDE;
            end
            FINISH: begin
                rd_d    = result;
                we_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // busy also covers the write cycle, when the state has already returned to IDLE
        busy_d = (state_d != IDLE) || (state_q == FINISH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= DivOp_t'(3'b000);
            addr_q    <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rd_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rd_q      <= rd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
        end
    end

    assign busy          = busy_q;
    assign rd            = rd_q;
    assign rdAddress     = addr_q;
    assign rdWriteEnable = we_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// tb_multicycle_divider: vector table, directed corner sequences and random ops against an arithmetic model.
module tb_multicycle_divider;
    import JZJCoreFTypes::*;

`ifdef JZJCOREF_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [4:0]  rdAddressIn = '0;
    logic        busy;
    logic [31:0] rd;
    logic [4:0]  rdAddress;
    logic        rdWriteEnable;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ad;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[14];

    multicycle_divider dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .dividend     (dividend),
        .divisor      (divisor),
        .rdAddressIn  (rdAddressIn),
        .busy         (busy),
        .rd           (rd),
        .rdAddress    (rdAddress),
        .rdWriteEnable(rdWriteEnable)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        sa = a;
        sb = b;
        if (b == '0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
        if (f3[0]) return f3[1] ? a % b : a / b;
        sq = sa / sb;
        sr = sa % sb;
        return f3[1] ? sr : sq;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (b == '0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (EARLY && special) ? 1 : DIV_LATENCY - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // waits for the write pulse, counting edges since the accepting edge
    task automatic wait_pulse(inout int lat, output bit busy_ok);
        busy_ok = 1'b1;
        while (!rdWriteEnable && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] ad, input logic [31:0] exp);
        int lat;
        bit busy_ok;
        funct3 = f3;
        dividend = a;
        divisor = b;
        rdAddressIn = ad;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        wait_pulse(lat, busy_ok);
        check({name, " rd"}, rd, exp);
        check({name, " rdAddress"}, 32'(rdAddress), 32'(ad));
        check({name, " latency"}, 32'(lat), 32'(exp_lat(f3, a, b)));
        check({name, " busy"}, 32'(busy_ok), 32'd1);
        tick();
        check({name, " single pulse"}, {30'd0, rdWriteEnable, busy}, 32'd0);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (rdWriteEnable) n++;
        end
    endtask

    initial begin
        int lat, n;
        bit busy_ok;
        logic [2:0] f3;
        logic [31:0] a, b;
        vecs[0]  = '{3'b101, 32'd100,        32'd7,          5'd5,  32'd14};
        vecs[1]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD};
        vecs[2]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF};
        vecs[3]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd3,  32'h8000_0000};
        vecs[4]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd4,  32'd0};
        vecs[5]  = '{3'b101, 32'd123,        32'd0,          5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'b110, 32'hFFFF_FFFB,  32'd0,          5'd7,  32'hFFFF_FFFB};
        vecs[7]  = '{3'b100, 32'hFFFF_FFFB,  32'd0,          5'd8,  32'hFFFF_FFFF};
        vecs[8]  = '{3'b100, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD};
        vecs[9]  = '{3'b110, 32'd7,          32'hFFFF_FFFE,  5'd10, 32'd1};
        vecs[10] = '{3'b111, 32'd100,        32'd7,          5'd0,  32'd2};
        vecs[11] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF};
        vecs[12] = '{3'b111, 32'hFFFF_FFFF,  32'h8000_0000,  5'd12, 32'h7FFF_FFFF};
        vecs[13] = '{3'b100, 32'h8000_0000,  32'd2,          5'd13, 32'hC000_0000};

        repeat (3) tick();
        check("reset outputs", {rd[0], rdAddress, busy, rdWriteEnable} | {25'd0, |rd, 6'd0}, 32'd0);
        reset = 1'b1;
        tick();

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].ad, vecs[i].exp_rd);

        // start pulsed mid-operation must not relaunch or re-latch
        funct3 = 3'b101;
        dividend = 32'd50;
        divisor = 32'd5;
        rdAddressIn = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        dividend = 32'd99;
        divisor = 32'd9;
        rdAddressIn = 5'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 10;
        wait_pulse(lat, busy_ok);
        check("busy start rd", rd, 32'd10);
        check("busy start rdAddress", 32'(rdAddress), 32'd3);
        check("busy start latency", 32'(lat), 32'(DIV_LATENCY - 1));
        count_pulses(40, n);
        check("busy start no relaunch", 32'(n), 32'd0);

        // reset mid-operation drops the result
        funct3 = 3'b101;
        dividend = 32'd1000;
        divisor = 32'd3;
        rdAddressIn = 5'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        reset = 1'b0;
        #1;
        check("mid reset busy", {30'd0, busy, rdWriteEnable}, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        count_pulses(40, n);
        check("mid reset no pulse", 32'(n), 32'd0);
        run_check("after reset", 3'b101, 32'd9, 32'd3, 5'd4, 32'd3);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            run_check($sformatf("rand%0d", i), f3, a, b, 5'($urandom_range(0, 31)), model(f3, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_divider.md
Name: multicycle_divider

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits upstream of the register file write port.
- Consumes the register file's rs1/rs2 read values plus the destination address.
- Produces the rd value with a one-cycle write-enable pulse on completion; the core stalls on busy.

Parameters:
- ITERATIONS, 32, quotient bits produced, one per cycle. Fixed at 32 for RV32; other values are unsupported and flagged by an elaboration-time assertion.

Ports:
- clock  input  1  core clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  sampled in IDLE only; launches an operation
- funct3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; other codes are illegal in the core
- dividend  input  32  rs1 value
- divisor  input  32  rs2 value
- rdAddressIn  input  5  destination register, latched with start
- busy  output  1  high from the cycle after start is accepted until the write cycle inclusive
- rd  output  32  result; valid only while rdWriteEnable=1
- rdAddress  output  5  latched destination
- rdWriteEnable  output  1  single-cycle pulse; the write port commits rd to rdAddress

Behaviour:
- Reset values: state=IDLE, busy=0, rdWriteEnable=0, rd=0, rdAddress=0, counter=0. All internal registers are cleared.
- States are IDLE -> DIVIDE -> FINISH -> IDLE.
- IDLE, start=1: latch funct3 and rdAddressIn.
  - Magnitudes: |dividend| and |divisor| for signed ops; raw values for unsigned ops.
  - Sign flags: negQ = signed & (dividend[31]^divisor[31]) & (divisor!=0); negR = signed & dividend[31].
  - Clear the 32-bit remainder accumulator; set counter=31; go to DIVIDE.
- IDLE, start=0: hold.
- DIVIDE, each cycle: shift {rem,quo} left by 1 and take the next dividend MSB.
  - If the 33-bit trial (rem - divisor) is non-negative: rem=trial, quotient bit=1; otherwise the quotient bit=0.
  - Counter decrements; after the cycle with counter=0, go to FINISH.
- FINISH: select quotient (DIV/DIVU) or remainder (REM/REMU).
  - Apply two's-complement negation per negQ/negR.
  - Drive rd, set rdWriteEnable=1 for exactly this cycle, go to IDLE.
- Latency: start accepted at edge N; rdWriteEnable is high during the cycle after edge N+33. Throughput is one operation per 34 cycles. A new start is accepted in the cycle rdWriteEnable is high (state returns to IDLE on that edge).
- Magnitude of -2^31 is 0x80000000 treated as unsigned 32-bit; no overflow in the datapath.
- Divide by zero (falls out of the algorithm): quotient=0xFFFFFFFF; remainder=dividend, sign restored by negR.
- Signed overflow (-2^31 / -1): quotient=0x80000000, remainder=0.
- start while busy: ignored; operands are not re-latched.
- rdAddress=0: the operation runs normally and the write pulse still fires; the register file discards x0 writes.
- reset asserted mid-operation: immediate return to IDLE, no write pulse, partial result discarded.
- Outputs are registered; no combinational path from inputs to rd or rdWriteEnable.

Optional Feature:
- Macro: JZJCOREF_DIV_EARLY_OUT_EN
- Defined: in IDLE with start=1, divisor==0 or (signed & dividend==0x80000000 & divisor==0xFFFFFFFF) jumps straight to FINISH with the precomputed quotient/remainder. rdWriteEnable then fires in the cycle after edge N+1.
- Undefined: all operations take the full 34-cycle path; results are identical either way.

Decomposition:
- Package JZJCoreFTypes:
  - DivState_t enum {IDLE, DIVIDE, FINISH}
  - DivOp_t enum for the four funct3 codes
  - constant DIV_LATENCY=34
- One natural sub-module: divider_sign_fixup. Combinational; takes quotient, remainder, op, negQ, negR and returns the final 32-bit result. Reusable by any later multiplier/divider finish stage.

Test Plan:
- DIVU 100/7, rdAddressIn=5: rd=14, rdAddress=5, a single write pulse 34 cycles after start, busy high throughout.
- DIV -7/2 and REM -7/2: rd=0xFFFFFFFD (-3) and rd=0xFFFFFFFF (-1).
- DIV 0x80000000/0xFFFFFFFF: rd=0x80000000; REM of the same operands: rd=0.
- DIVU 123/0: rd=0xFFFFFFFF; REM -5/0: rd=0xFFFFFFFB; DIV -5/0: rd=0xFFFFFFFF. With JZJCOREF_DIV_EARLY_OUT_EN the pulse comes 2 cycles after start.
- start pulsed again at cycle 10 of DIVU 50/5 with different operands: the result is still 10 and no second operation launches.
- reset driven low at cycle 15 of an operation, released 2 cycles later: busy=0, no write pulse. A following DIVU 9/3 returns rd=3 with normal latency.
